// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define DIV_RESULT_CACHE_EN to reuse the last computed quotient/remainder.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             START,
  input  logic             KILL,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_rem;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;

`ifdef DIV_RESULT_CACHE_EN
  logic             from_calc;
  logic [WIDTH-1:0] op_d1;
  logic [WIDTH-1:0] op_d2;
  logic             op_sgn;
  logic             c_valid;
  logic [WIDTH-1:0] c_d1;
  logic [WIDTH-1:0] c_d2;
  logic             c_sgn;
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] c_r;
`endif

  logic             sgn;
  logic             s1;
  logic             s2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic             div0;
  logic             ovf;
  logic             hit;
  logic [WIDTH-1:0] sp_q;
  logic [WIDTH-1:0] sp_r;

  always_comb begin
    sgn  = ~OP[0];
    s1   = sgn & DATA1[WIDTH-1];
    s2   = sgn & DATA2[WIDTH-1];
    mag1 = s1 ? -DATA1 : DATA1;
    mag2 = s2 ? -DATA2 : DATA2;
    div0 = (DATA2 == '0);
    ovf  = sgn & (DATA1 == MIN) & (&DATA2);
`ifdef DIV_RESULT_CACHE_EN
    hit  = c_valid & (c_d1 == DATA1) &
           (c_d2 == DATA2) & (c_sgn == sgn);
`else
    hit  = 1'b0;
`endif
    sp_q = '0;
    sp_r = '0;
    unique case (1'b1)
      div0: begin
        sp_q = '1;
        sp_r = DATA1;
      end
      ovf: begin
        sp_q = MIN;
        sp_r = '0;
      end
`ifdef DIV_RESULT_CACHE_EN
      hit: begin
        sp_q = c_q;
        sp_r = c_r;
      end
`endif
      default: begin
        sp_q = '0;
        sp_r = '0;
      end
    endcase
  end

  // One restoring step: shift in the next dividend bit, try the subtract.
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] sub;
  logic [WIDTH-1:0] q_f;
  logic [WIDTH-1:0] r_f;

  always_comb begin
    trial = {rem, dvd[WIDTH-1]};
    ge    = (trial >= {1'b0, dvs});
    sub   = trial[WIDTH-1:0] - dvs;
    q_f   = q_neg ? -dvd : dvd;
    r_f   = r_neg ? -rem : rem;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state  <= IDLE;
      cnt    <= '0;
      op_rem <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= '0;
`ifdef DIV_RESULT_CACHE_EN
      from_calc <= 1'b0;
      op_d1     <= '0;
      op_d2     <= '0;
      op_sgn    <= 1'b0;
      c_valid   <= 1'b0;
      c_d1      <= '0;
      c_d2      <= '0;
      c_sgn     <= 1'b0;
      c_q       <= '0;
      c_r       <= '0;
`endif
    end else begin
      DONE <= 1'b0;
      if (BUSY && KILL) begin
        state <= IDLE;
        BUSY  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (START && !KILL) begin
              op_rem <= OP[1];
              BUSY   <= 1'b1;
              cnt    <= '0;
              if (div0 || ovf || hit) begin
                dvd   <= sp_q;
                rem   <= sp_r;
                q_neg <= 1'b0;
                r_neg <= 1'b0;
                state <= FIX;
`ifdef DIV_RESULT_CACHE_EN
                from_calc <= 1'b0;
`endif
              end else begin
                dvd   <= mag1;
                dvs   <= mag2;
                rem   <= '0;
                q_neg <= s1 ^ s2;
                r_neg <= s1;
                state <= CALC;
`ifdef DIV_RESULT_CACHE_EN
                from_calc <= 1'b1;
                op_d1     <= DATA1;
                op_d2     <= DATA2;
                op_sgn    <= sgn;
`endif
              end
            end
          end
          CALC: begin
            rem <= ge ? sub : trial[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], ge};
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) begin
              state <= FIX;
            end
          end
          FIX: begin
            RESULT <= op_rem ? r_f : q_f;
            DONE   <= 1'b1;
            BUSY   <= 1'b0;
            state  <= IDLE;
`ifdef DIV_RESULT_CACHE_EN
            if (from_calc) begin
              c_valid <= 1'b1;
              c_d1    <= op_d1;
              c_d2    <= op_d2;
              c_sgn   <= op_sgn;
              c_q     <= q_f;
              c_r     <= r_f;
            end
`endif
          end
          default: begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
